// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC hall-sensor front end.
//   meter_state_t : period meter states (IDLE, WARMUP, FIRST, RUN)
//   FWD_SUCC      : forward successor of each hall code (1->3->2->6->4->5->1)
//   REV_PRED      : predecessor of each hall code (reverse rotation)
//   CODE_INV_*    : the two hall codes that can never occur on a healthy motor
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_FIRST  = 2'd2,
    ST_RUN    = 2'd3
  } meter_state_t;

  localparam logic [2:0] CODE_INV_LO = 3'b000;
  localparam logic [2:0] CODE_INV_HI = 3'b111;

  // Indexed by the current code; entries 0 and 7 map to 0 so they never match a valid code.
  localparam logic [2:0] FWD_SUCC [8] = '{3'd0, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0};
  localparam logic [2:0] REV_PRED [8] = '{3'd0, 3'd5, 3'd3, 3'd1, 3'd6, 3'd4, 3'd2, 3'd0};

  function automatic logic is_invalid_code(input logic [2:0] code);
    return (code == CODE_INV_LO) || (code == CODE_INV_HI);
  endfunction

endpackage

// File: rtl/hall_debouncer.sv
// Synchronises and debounces the three raw hall lines.
//   clk, reset      : clock, asynchronous active-high reset
//   run             : debounce active; when low the candidate and counter hold
//   hall            : raw hall lines (asynchronous to clk)
//   accept_c        : strobe, a new valid code is accepted at the end of this cycle
//   invalid_c       : strobe, a stable invalid code (000/111) has been seen (once per episode)
//   cand_code       : current debounce candidate (the code being accepted when accept_c)
//   code            : last accepted code
module hall_debouncer
  import bldc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] hall,
  output logic       accept_c,
  output logic       invalid_c,
  output logic [2:0] cand_code,
  output logic [2:0] code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [CNT_W-1:0] deb_cnt;
  logic             stable;
  logic             differs;
  logic             ripe;

  assign stable  = (sync2 == cand_code);
  assign differs = (cand_code != code);
  // Counter parks one past the acceptance point, so an invalid episode strobes only once.
  assign ripe    = run && stable && differs && (deb_cnt == CNT_LAST);

  assign accept_c  = ripe && !is_invalid_code(cand_code);
  assign invalid_c = ripe &&  is_invalid_code(cand_code);

  // Two-flop synchroniser, always running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
    end
  end

  // Candidate tracking, stability count and accepted code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_code <= 3'b000;
      deb_cnt   <= '0;
      code      <= 3'b000;
    end else if (run) begin
      cand_code <= sync2;
      if (!stable) begin
        deb_cnt <= '0;
      end else if (differs && (deb_cnt != CNT_SAT)) begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
      if (accept_c) begin
        code <= cand_code;
      end
    end
  end

endmodule

// File: rtl/hall_period_meter.sv
// Measures the hall commutation period and averages it over 2^AVG_SHIFT samples.
//   clk, reset    : clock, asynchronous active-high reset
//   enable        : measurement enable (low parks the meter in IDLE)
//   hall          : raw hall sensor lines
//   period_speed  : averaged period in clock cycles (all ones when stalled)
//   period_valid  : one-cycle pulse when period_speed updates
//   stalled       : no valid transition within 2^DATA_WIDTH-1 cycles
//   direction     : 1 = forward rotation, 0 = reverse
//   hall_fault    : one-cycle pulse on an invalid code or a non-adjacent jump
module hall_period_meter
  import bldc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned AVG_SHIFT       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            hall,
  output logic [DATA_WIDTH-1:0] period_speed,
  output logic                  period_valid,
  output logic                  stalled,
  output logic                  direction,
  output logic                  hall_fault
);

  localparam int unsigned DEPTH = 1 << AVG_SHIFT;
  localparam int unsigned SUM_W = DATA_WIDTH + AVG_SHIFT;
  localparam int unsigned PTR_W = (AVG_SHIFT == 0) ? 1 : AVG_SHIFT;
  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(DEPTH - 1);

  meter_state_t          state;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] ring [DEPTH];
  logic [PTR_W-1:0]      ptr;
  logic [SUM_W-1:0]      sum;
  logic                  publish;

  logic                  run;
  logic                  accept_c;
  logic                  invalid_c;
  logic [2:0]            cand_code;
  logic [2:0]            code;
  logic                  adj_fwd;
  logic                  adj_rev;

  assign run     = enable && (state != ST_IDLE);
  assign adj_fwd = (cand_code == FWD_SUCC[code]);
  assign adj_rev = (cand_code == REV_PRED[code]);

  hall_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .hall      (hall),
    .accept_c  (accept_c),
    .invalid_c (invalid_c),
    .cand_code (cand_code),
    .code      (code)
  );

  // Meter FSM, period counter, averaging ring and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_WARMUP;
      cnt          <= '0;
      ptr          <= '0;
      sum          <= '0;
      publish      <= 1'b0;
      period_speed <= '1;
      period_valid <= 1'b0;
      stalled      <= 1'b1;
      direction    <= 1'b0;
      hall_fault   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring[i] <= '0;
      end
    end else begin
      period_valid <= 1'b0;
      hall_fault   <= 1'b0;
      publish      <= 1'b0;

      // Sum settled on the previous edge; present it one cycle later.
      if (publish) begin
        period_speed <= DATA_WIDTH'(sum >> AVG_SHIFT);
        period_valid <= 1'b1;
      end

      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WARMUP;
          end
          ST_WARMUP: begin
            if (accept_c) begin
              cnt   <= DATA_WIDTH'(1);
              state <= ST_FIRST;
            end
          end
          ST_FIRST, ST_RUN: begin
            // An accepted edge takes priority over counter saturation.
            if (accept_c) begin
              cnt <= DATA_WIDTH'(1);
              if (adj_fwd || adj_rev) begin
                direction <= adj_fwd;
                publish   <= 1'b1;
                if (state == ST_FIRST) begin
                  for (int i = 0; i < int'(DEPTH); i++) begin
                    ring[i] <= cnt;
                  end
                  sum     <= SUM_W'(cnt) << AVG_SHIFT;
                  ptr     <= '0;
                  stalled <= 1'b0;
                  state   <= ST_RUN;
                end else begin
                  sum       <= sum - SUM_W'(ring[ptr]) + SUM_W'(cnt);
                  ring[ptr] <= cnt;
                  ptr       <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
                end
              end else begin
                hall_fault <= 1'b1;
                state      <= ST_FIRST;
              end
            end else if (cnt == CNT_MAX) begin
              stalled      <= 1'b1;
              period_speed <= '1;
              period_valid <= 1'b1;
              state        <= ST_WARMUP;
            end else begin
              cnt <= cnt + DATA_WIDTH'(1);
            end
          end
          default: begin
            state <= ST_WARMUP;
          end
        endcase

        if (invalid_c) begin
          hall_fault <= 1'b1;
        end
      end
    end
  end

endmodule
